// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding reused by stages and benches.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/en_reg.sv
// Enabled register with synchronous active-high clear; holds one payload word.
module en_reg #(
  parameter int BITLENGTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [BITLENGTH-1:0] d,
  output logic [BITLENGTH-1:0] q
);

  logic [BITLENGTH-1:0] data_q;
  logic [BITLENGTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: fully registered outputs, one transfer per cycle, flushable.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int BITLENGTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [BITLENGTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [BITLENGTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  skid_state_e          state_q, state_d;
  logic                 main_en, skid_en;
  logic [BITLENGTH-1:0] main_d, main_q, skid_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state plus register enables; flush squashes every load but leaves data intact.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    unique case (state_q)
      EMPTY: begin
        if (in_valid) begin
          state_d = FULL;
          main_en = 1'b1;
        end
      end
      FULL: begin
        if (in_valid && out_ready) begin
          main_en = 1'b1;
        end else if (in_valid) begin
          state_d = SKID;
          skid_en = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_ready) begin
          state_d = FULL;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != SKID) && !reset;
    count     = state_q;
  end

  en_reg #(.BITLENGTH(BITLENGTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  en_reg #(.BITLENGTH(BITLENGTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table followed by randomized stress against a queue model.
module tb_pipe_skid_reg;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(.BITLENGTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic [1:0]   cnt;
    logic         ov;
    logic         ir;
    logic [W-1:0] od;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [W-1:0] d,
                     input logic ordy, input logic [1:0] cnt, input logic ov, input logic ir,
                     input logic [W-1:0] od);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.od = od;
    vq.push_back(v);
  endtask

  // Reference: a bounded queue; occupancy, head and readiness follow directly from its size.
  logic [W-1:0] mq[$];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //   rst fl iv data      ordy cnt ov ir out_data
    add(1, 0, 0, 64'h0,     0,   0,  0, 0, 64'h0);
    add(0, 0, 0, 64'h0,     0,   0,  0, 1, 64'h0);
    add(0, 0, 1, 64'h1,     1,   1,  1, 1, 64'h1);
    add(0, 0, 1, 64'h2,     1,   1,  1, 1, 64'h2);
    add(0, 0, 1, 64'h3,     1,   1,  1, 1, 64'h3);
    add(0, 0, 0, 64'h0,     1,   0,  0, 1, 64'h3);
    add(0, 0, 1, 64'hA,     0,   1,  1, 1, 64'hA);
    add(0, 0, 1, 64'hB,     0,   2,  1, 0, 64'hA);
    add(0, 0, 1, 64'hC,     0,   2,  1, 0, 64'hA);
    add(0, 0, 1, 64'hC,     1,   1,  1, 1, 64'hB);
    add(0, 0, 1, 64'hC,     1,   1,  1, 1, 64'hC);
    add(0, 0, 0, 64'h0,     1,   0,  0, 1, 64'hC);
    add(0, 0, 1, 64'hA,     0,   1,  1, 1, 64'hA);
    add(0, 0, 1, 64'hB,     0,   2,  1, 0, 64'hA);
    add(0, 1, 1, 64'hC,     0,   0,  0, 1, 64'hA);
    add(0, 0, 0, 64'h0,     1,   0,  0, 1, 64'hA);
    add(0, 0, 1, 64'h5,     0,   1,  1, 1, 64'h5);
    add(0, 0, 1, 64'h6,     0,   2,  1, 0, 64'h5);
    add(1, 1, 1, 64'h7,     1,   0,  0, 0, 64'h0);
    add(0, 0, 0, 64'h0,     0,   0,  0, 1, 64'h0);
    add(0, 0, 0, 64'hFFFF,  1,   0,  0, 1, 64'h0);

    foreach (vq[i]) begin
      reset = vq[i].rst; flush = vq[i].fl; in_valid = vq[i].iv;
      in_data = vq[i].d; out_ready = vq[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d count", i),     64'(count),     64'(vq[i].cnt));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vq[i].ov));
      chk($sformatf("vec%0d in_ready", i),  64'(in_ready),  64'(vq[i].ir));
      chk($sformatf("vec%0d out_data", i),  out_data,       vq[i].od);
    end

    // Hand sequence: in_ready must drop combinationally as soon as reset rises.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("in_ready during reset", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("in_ready after reset", 64'(in_ready), 64'h1);
    mq.delete();

    // Randomized stress against the queue model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit exp_ir, take_in, take_out;
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      #1;
      exp_ir = !reset && (mq.size() < 2);
      chk("rand in_ready", 64'(in_ready), 64'(exp_ir));
      take_in  = in_valid && exp_ir;
      take_out = out_ready && (mq.size() > 0);
      if (reset || flush) begin
        mq.delete();
      end else begin
        if (take_out) void'(mq.pop_front());
        if (take_in)  mq.push_back(in_data);
      end
      @(posedge clk); #1;
      checks++;
      if (count == 2'd3) begin
        errors++;
        $display("FAIL rand count legal: got 3 expected 0..2");
      end
      chk("rand count", 64'(count), 64'(mq.size()));
      chk("rand out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("rand out_data", out_data, mq[0]);
      else if (reset)    chk("rand out_data after reset", out_data, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter BITLENGTH, default 64, payload width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  reset; synchronous and active-high, one clock domain.
REQ-004 SHALL have port flush  input  1  discard all held entries (pipeline squash).
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_data  input  BITLENGTH  upstream payload.
REQ-007 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-009 SHALL have port out_data  output  BITLENGTH  head payload.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL have port count  output  2  occupancy, 0..2.

Function
REQ-012 SHALL count an input transfer only on a cycle with in_valid & in_ready, and an output transfer only on a cycle with out_valid & out_ready.
REQ-013 SHALL hold two BITLENGTH storage registers, main (head) and skid (overflow).
REQ-014 SHALL implement states EMPTY (count 0), FULL (count 1, main valid) and SKID (count 2, main and skid valid).
REQ-015 SHALL drive out_valid = (state != EMPTY), in_ready = (state != SKID) & !reset, and out_data = main, with no combinational path from in_valid/in_data to out_*.
REQ-016 SHALL go from EMPTY to FULL with main <= in_data when in_valid is high; otherwise it SHALL stay in EMPTY.
REQ-017 SHALL handle FULL as follows: in_valid & out_ready: stay FULL, main <= in_data (same-cycle pass-through, 1-cycle latency).
REQ-018 SHALL handle FULL as follows: in_valid & !out_ready: go to SKID, skid <= in_data, main unchanged.
REQ-019 SHALL handle FULL as follows: !in_valid & out_ready: go to EMPTY.
REQ-020 SHALL stay in FULL when both in_valid and out_ready are low.
REQ-021 SHALL handle SKID as follows: out_ready: go to FULL, main <= skid; otherwise stay in SKID; no input is accepted in SKID.
REQ-022 SHALL have a minimum latency of exactly 1 cycle from input transfer to out_valid, and SHALL sustain throughput of one transfer per cycle with out_ready held high.
REQ-023 SHALL deliver entries in strict FIFO order and SHALL never drop or duplicate an entry absent flush or reset.
REQ-024 SHALL make flush the highest priority after reset: next state is EMPTY and count is 0, and any input transfer in the flush cycle is discarded.
REQ-025 SHALL treat an output transfer in the flush cycle as completed (downstream owns it).
REQ-026 SHALL hold data register contents without modification on flush, because the contents are don't-care once out_valid is low.
REQ-027 SHALL drive count as a registered encoding of state (EMPTY=0, FULL=1, SKID=2); the value 3 is illegal and SHALL never appear.
REQ-028 SHALL be insensitive to in_data while in_valid is low, and to out_ready while out_valid is low.

Reset
REQ-029 SHALL, when reset is high at posedge clk, set state to EMPTY, main and skid to 0, count to 0, out_valid to 0 and out_data to 0.
REQ-030 SHALL let reset override flush, in_valid and out_ready in the same cycle, including mid-operation with SKID occupied.
REQ-031 SHALL force in_ready low while reset is high, and SHALL raise in_ready on the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the state enum skid_state_e {EMPTY, FULL, SKID} in shared package pipe_pkg, so that other pipeline stages and benches reuse it.
REQ-033 SHALL implement main and skid with one sub-module, en_reg: a BITLENGTH-parameterised enabled register with synchronous active-high reset to 0, instantiated twice.
REQ-034 SHALL keep the next-state and enable logic in pipe_skid_reg.

Verification
REQ-035 SHALL cover streaming: BITLENGTH=64, out_ready=1, in_data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following consecutive cycles, count stays 1, in_ready stays 1.
REQ-036 SHALL cover back-pressure: out_ready=0, offer 0xA then 0xB -> count 2, in_ready 0, 0xC held off; then out_ready=1 -> 0xA, 0xB, 0xC emerge in order with no loss.
REQ-037 SHALL cover flush in SKID: state SKID holding 0xA/0xB, flush=1 with in_valid=1 (0xC) -> next cycle count 0, out_valid 0; 0xA, 0xB and 0xC are never observed.
REQ-038 SHALL cover reset mid-operation: count 2, assert reset one cycle with flush=1, in_valid=1 -> count 0, out_data 0, out_valid 0; in_ready 0 during reset and 1 the cycle after.
REQ-039 SHALL cover random stress: 10,000 cycles of random in_valid/out_ready/flush against a scoreboard queue -> order is preserved, count never 3, no transfer while in_ready is low.
